// File: rtl/serial_borrow_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, SLICE bits per clock.
// One slice subtractor is reused each cycle with a registered borrow chain.
module serial_borrow_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("serial_borrow_sub: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       res_q;
    logic                   borrow_q;
    logic [CW-1:0]          cnt_q;
    logic [SLICE:0]         sub;
    logic [WIDTH+SLICE-1:0] cat;
    logic [WIDTH-1:0]       res_nx;
    logic                   last;

    // Top bit of the (SLICE+1)-bit difference is the slice borrow-out.
    assign sub = {1'b0, a_q[SLICE-1:0]}
               - {1'b0, b_q[SLICE-1:0]}
               - {{SLICE{1'b0}}, borrow_q};

    // New slice enters at the MSB end; after N slices the result is LSB-aligned.
    assign cat    = {sub[SLICE-1:0], res_q} >> SLICE;
    assign res_nx = cat[WIDTH-1:0];
    assign last   = (cnt_q == LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> SLICE;
                    b_q      <= b_q >> SLICE;
                    borrow_q <= sub[SLICE];
                    res_q    <= res_nx;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        diff <= res_nx;
                        bout <= sub[SLICE];
                        zero <= (res_nx == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_borrow_sub.sv
// Bench for serial_borrow_sub: 16/4 with a timing+arithmetic model,
// plus exhaustive 3/1 and 1/1 sweeps.
module tb_serial_borrow_sub;

    localparam int N16 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic        v16 = 0, r16, ov16, or16 = 0, bin16 = 0, bo16, z16;
    logic [15:0] a16 = 0, b16 = 0, d16;

    logic       v3 = 0, r3, ov3, or3 = 0, bin3 = 0, bo3, z3;
    logic [2:0] a3 = 0, b3 = 0, d3;

    logic v1 = 0, r1, ov1, or1 = 0, bin1 = 0, bo1, z1;
    logic a1 = 0, b1 = 0, d1;

    serial_borrow_sub #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(or16),
        .diff(d16), .bout(bo16), .zero(z16)
    );

    serial_borrow_sub #(.WIDTH(3), .SLICE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3),
        .a(a3), .b(b3), .bin(bin3), .out_valid(ov3), .out_ready(or3),
        .diff(d3), .bout(bo3), .zero(z3)
    );

    serial_borrow_sub #(.WIDTH(1), .SLICE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
        .diff(d1), .bout(bo1), .zero(z1)
    );

    // Model of the 16-bit instance: busy for N16 edges after accept,
    // then presents the arithmetic result until out_ready.
    int          cyc = 0;
    int          acc = 0;
    logic        m_on = 0, m_pend = 0;
    logic [15:0] m_res = 0, m_d = 0;
    logic        m_rb = 0, m_b = 0, m_z = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_on   = 1;
            m_pend = 0;
            m_d    = 0;
            m_b    = 0;
            m_z    = 0;
        end else if (m_on) begin
            if (m_pend && (cyc - 1 - acc) >= N16 && or16) begin
                m_pend = 0;
            end else if (!m_pend && v16) begin
                m_pend = 1;
                acc    = cyc;
                m_res  = a16 - b16 - {15'b0, bin16};
                m_rb   = int'(a16) < int'(b16) + int'(bin16);
            end
            if (m_pend && (cyc - acc) == N16) begin
                m_d = m_res;
                m_b = m_rb;
                m_z = (m_res == 16'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready",  32'(r16),  32'(!m_pend));
            chk("out_valid", 32'(ov16), 32'(m_pend && (cyc - acc) >= N16));
            chk("diff",      32'(d16),  32'(m_d));
            chk("bout",      32'(bo16), 32'(m_b));
            chk("zero",      32'(z16),  32'(m_z));
        end
    end

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] xd, input logic xb, input logic xz,
                        input bit hold);
        int k;
        a16 = a; b16 = b; bin16 = bin; v16 = 1;
        @(posedge clk); #1 v16 = 0;
        k = 0;
        while (!ov16 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency",    32'(k),    32'(N16));
        chk("lit_diff",   32'(d16),  32'(xd));
        chk("lit_bout",   32'(bo16), 32'(xb));
        chk("lit_zero",   32'(z16),  32'(xz));
        chk("model_diff", 32'(m_d),  32'(xd));
        if (hold) begin
            repeat (5) begin
                v16 = 1'($urandom);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                @(posedge clk); #1;
                chk("hold_ov",   32'(ov16), 32'(1));
                chk("hold_rdy",  32'(r16),  32'(0));
                chk("hold_diff", 32'(d16),  32'(xd));
                chk("hold_bout", 32'(bo16), 32'(xb));
            end
            v16 = 0;
        end
        or16 = 1;
        @(posedge clk); #1 or16 = 0;
        chk("ret_rdy", 32'(r16),  32'(1));
        chk("ret_ov",  32'(ov16), 32'(0));
    endtask

    logic [1:0] fs_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [3:0] e3;
        logic [1:0] e1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_rdy",  32'(r16),  32'(1));
        chk("rst_ov",   32'(ov16), 32'(0));
        chk("rst_diff", 32'(d16),  32'(0));
        chk("rst_bout", 32'(bo16), 32'(0));
        chk("rst_zero", 32'(z16),  32'(0));

        op16(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
        op16(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0);
        op16(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        op16(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0);

        // Reset on the second RUN edge discards the operation.
        a16 = 16'h8000; b16 = 16'h0001; bin16 = 0; v16 = 1;
        @(posedge clk); #1 v16 = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("mid_rdy",  32'(r16),  32'(1));
        chk("mid_ov",   32'(ov16), 32'(0));
        chk("mid_diff", 32'(d16),  32'(0));
        repeat (8) begin
            @(posedge clk); #1;
            chk("mid_noout", 32'(ov16), 32'(0));
        end

        op16(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1);

        for (int i = 0; i < 128; i++) begin
            a3 = 3'(i); b3 = 3'(i >> 3); bin3 = 1'(i >> 6); v3 = 1;
            @(posedge clk); #1 v3 = 0;
            k = 0;
            while (!ov3 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            e3 = 4'(int'(a3) - int'(b3) - int'(bin3));
            chk("w3_lat", 32'(k), 32'(3));
            chk("w3_res", 32'({bo3, d3}), 32'(e3));
            or3 = 1;
            @(posedge clk); #1 or3 = 0;
        end

        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; bin1 = i[0]; v1 = 1;
            @(posedge clk); #1 v1 = 0;
            k = 0;
            while (!ov1 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            e1 = 2'(int'(a1) - int'(b1) - int'(bin1));
            chk("fs_lat",   32'(k), 32'(1));
            chk("fs_res",   32'({bo1, d1}), 32'(e1));
            chk("fs_table", 32'(e1), 32'(fs_tab[i]));
            or1 = 1;
            @(posedge clk); #1 or1 = 0;
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
